// File: rtl/ssd_msg_encoder.sv
// Seven-segment message encoder: 8-entry character buffer, 4-digit window,
// timed left-scroll FSM, per-digit blink and decimal point, registered outputs.
module ssd_msg_encoder #(
    parameter int MSG_LEN    = 8,
    parameter int SCROLL_DIV = 50_000_000,
    parameter int BLINK_DIV  = 25_000_000
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
    input  logic [4:0]                 wr_char,
    input  logic                       start,
    input  logic                       repeat_en,
    input  logic [3:0]                 blink_mask,
    input  logic [3:0]                 dp_mask,
    output logic [7:0]                 disp0,
    output logic [7:0]                 disp1,
    output logic [7:0]                 disp2,
    output logic [7:0]                 disp3,
    output logic                       busy,
    output logic                       done
);

    localparam int AW = $clog2(MSG_LEN);
    localparam int SW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] STEP_LAST  = SW'(SCROLL_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [AW-1:0] POS_LAST   = AW'(MSG_LEN - 1);
    localparam logic [4:0]    CHAR_BLANK = 5'd16;

    typedef enum logic [0:0] {
        ST_STATIC = 1'b0,
        ST_SCROLL = 1'b1
    } state_e;

    function automatic logic [7:0] enc_char(input logic [4:0] code);
        logic [7:0] seg;
        case (code)
            5'd0:    seg = 8'hC0;
            5'd1:    seg = 8'hF9;
            5'd2:    seg = 8'hA4;
            5'd3:    seg = 8'hB0;
            5'd4:    seg = 8'h99;
            5'd5:    seg = 8'h92;
            5'd6:    seg = 8'h82;
            5'd7:    seg = 8'hF8;
            5'd8:    seg = 8'h80;
            5'd9:    seg = 8'h90;
            5'd10:   seg = 8'h88;
            5'd11:   seg = 8'h83;
            5'd12:   seg = 8'hC6;
            5'd13:   seg = 8'hA1;
            5'd14:   seg = 8'h86;
            5'd15:   seg = 8'h8E;
            5'd16:   seg = 8'hFF;
            5'd17:   seg = 8'hBF;
            5'd18:   seg = 8'h89;
            5'd19:   seg = 8'hC7;
            5'd20:   seg = 8'h8C;
            5'd21:   seg = 8'hAF;
            5'd22:   seg = 8'hA3;
            5'd23:   seg = 8'hC1;
            5'd24:   seg = 8'hAB;
            default: seg = 8'hFF;
        endcase
        return seg;
    endfunction

    // Blank overrides everything (dp included) during the off phase of a blinking digit
    function automatic logic [7:0] apply_mods(input logic [7:0] seg, input logic blank, input logic dp);
        logic [7:0] res;
        if (blank) begin
            res = 8'hFF;
        end else if (dp) begin
            res = seg & 8'h7F;
        end else begin
            res = seg;
        end
        return res;
    endfunction

    state_e          state_q, state_d;
    logic [AW-1:0]   pos_q, pos_d;
    logic [SW-1:0]   step_q, step_d;
    logic [BW-1:0]   blink_cnt_q, blink_cnt_d;
    logic            blink_phase_q, blink_phase_d;
    logic            done_q, done_d;
    logic [4:0]      msg_q [MSG_LEN];
    logic [7:0]      disp_q [4];
    logic [7:0]      disp_d [4];
    logic            step_tc_s;
    logic            wrap_s;
    logic            busy_s;

    assign step_tc_s = (step_q == STEP_LAST);
    assign wrap_s    = (state_q == ST_SCROLL) && step_tc_s && (pos_q == POS_LAST) && !start;

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_STATIC;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: start always (re)enters SCROLL; a completed pass leaves it unless repeating
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STATIC: begin
                if (start) begin
                    state_d = ST_SCROLL;
                end else begin
                    state_d = ST_STATIC;
                end
            end
            ST_SCROLL: begin
                if (start) begin
                    state_d = ST_SCROLL;
                end else if (wrap_s && !repeat_en) begin
                    state_d = ST_STATIC;
                end else begin
                    state_d = ST_SCROLL;
                end
            end
            default: state_d = ST_STATIC;
        endcase
    end

    // FSM outputs decoded from the state register only
    always_comb begin
        busy_s = 1'b0;
        case (state_q)
            ST_STATIC: busy_s = 1'b0;
            ST_SCROLL: busy_s = 1'b1;
            default:   busy_s = 1'b0;
        endcase
    end

    // Scroll position, step counter and pass-complete pulse
    always_comb begin
        pos_d  = pos_q;
        step_d = step_q;
        done_d = 1'b0;
        if (state_q != ST_SCROLL || start) begin
            pos_d  = '0;
            step_d = '0;
        end else if (step_tc_s) begin
            step_d = '0;
            pos_d  = pos_q + AW'(1);
            done_d = wrap_s;
        end else begin
            step_d = step_q + SW'(1);
        end
    end

    // Free-running blink timebase, independent of the FSM
    always_comb begin
        if (blink_cnt_q == BLINK_LAST) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end else begin
            blink_cnt_d   = blink_cnt_q + BW'(1);
            blink_phase_d = blink_phase_q;
        end
    end

    // Window decode: disp3 is the leftmost character at pos, wrapping mod MSG_LEN
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            disp_d[i] = 8'hFF;
        end
        for (int i = 0; i < 4; i++) begin
            disp_d[i] = apply_mods(enc_char(msg_q[pos_q + AW'(3 - i)]),
                                   blink_mask[i] & blink_phase_q, dp_mask[i]);
        end
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos_q         <= '0;
            step_q        <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            pos_q         <= pos_d;
            step_q        <= step_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            done_q        <= done_d;
        end
    end

    // Message buffer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                msg_q[i] <= CHAR_BLANK;
            end
        end else if (wr_en) begin
            msg_q[wr_addr] <= wr_char;
        end else begin
            msg_q <= msg_q;
        end
    end

    // Registered segment outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                disp_q[i] <= 8'hFF;
            end
        end else begin
            disp_q <= disp_d;
        end
    end

    assign disp0 = disp_q[0];
    assign disp1 = disp_q[1];
    assign disp2 = disp_q[2];
    assign disp3 = disp_q[3];
    assign busy  = busy_s;
    assign done  = done_q;

endmodule
